// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: entry layout, NOP and default vectors.
package fetch_pkg;

  localparam int unsigned EntryPcW    = 32;
  localparam int unsigned EntryInstrW = 16;

  localparam logic [EntryInstrW-1:0] NopInstr         = '0;
  localparam logic [EntryPcW-1:0]    DefaultResetPc   = 32'h20;
  localparam logic [EntryPcW-1:0]    DefaultIntVector = 32'h0;

  typedef struct packed {
    logic [EntryPcW-1:0]    pc;
    logic [EntryInstrW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {pc, instr} entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  output fetch_entry_t             rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic            full;
  logic            do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (PtrW + 1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign rdata  = mem_q[rptr_q];
  assign count  = count_q;

  // Flush wins over a same-cycle push or pop; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)   wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  // Issue credit includes the in-flight read, so a push into a full buffer is a logic bug.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full && !flush))
        else $error("fetch_fifo: enqueue into full queue");
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: fetch PC, redirect priority, issue credit and prefetch queue.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W     = EntryPcW,
  parameter int unsigned       INSTR_W    = EntryInstrW,
  parameter int unsigned       MEM_ADDR_W = 20,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = DefaultResetPc,
  parameter logic [ADDR_W-1:0] INT_VECTOR = DefaultIntVector
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0]    imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_addr,
  input  logic                  interrupt,
  input  logic                  pc_low_load,
  input  logic                  pc_high_load,
  input  logic [15:0]           pop_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INSTR_W-1:0]    out_instr,
  output logic [ADDR_W-1:0]     out_pc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q;
  logic              inflight_q, kill_q;
  logic              redirect, issue, pop, push, empty;
  logic [CntW-1:0]   count;
  fetch_entry_t      wr_entry, head;

  assign redirect = interrupt | redirect_valid | pc_low_load | pc_high_load;
  assign pop      = out_valid && out_ready;

  // A head popped this cycle frees its slot before the new read can return.
  assign issue = !redirect &&
                 (int'(count) - int'(pop) + int'(inflight_q) + 1 <= int'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q[MEM_ADDR_W-1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (interrupt) begin
      fetch_pc_d = INT_VECTOR;
    end else if (redirect_valid) begin
      fetch_pc_d = redirect_addr;
    end else if (pc_low_load || pc_high_load) begin
      if (pc_low_load)  fetch_pc_d[15:0]  = pop_data;
      if (pc_high_load) fetch_pc_d[31:16] = pop_data;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      kill_q     <= redirect;
      if (issue) inflight_pc_q <= fetch_pc_q;
    end
  end

  assign push           = inflight_q && !kill_q;
  assign wr_entry.pc    = inflight_pc_q;
  assign wr_entry.instr = imem_data;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .count (count)
  );

  assign out_valid = !empty;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : NopInstr;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: stream-level model plus directed timing checks.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [19:0] imem_addr;
  logic [15:0] imem_data = 16'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = 32'h0;
  logic        interrupt = 1'b0;
  logic        pc_low_load = 1'b0;
  logic        pc_high_load = 1'b0;
  logic [15:0] pop_data = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .interrupt      (interrupt),
    .pc_low_load    (pc_low_load),
    .pc_high_load   (pc_high_load),
    .pop_data       (pop_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [19:0] a);
    case (a)
      20'h20:  return 16'hAAA1;
      20'h21:  return 16'hBBB2;
      20'h22:  return 16'hCCC3;
      20'h23:  return 16'hDDD4;
      default: return a[15:0] ^ 16'h5A5A;
    endcase
  endfunction

  // Synchronous instruction memory; garbage when not requested.
  always @(posedge clk) imem_data <= imem_req ? mem_f(imem_addr) : 16'hDEAD;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: next PC to fetch, PC the head must carry, reads issued but not yet consumed.
  logic [31:0] m_fetch = 32'h20;
  logic [31:0] m_head  = 32'h20;
  int          m_out   = 0;

  initial begin
    logic        redir, pop;
    logic [31:0] tgt;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_fetch = 32'h20;
        m_head  = 32'h20;
        m_out   = 0;
        check("rst_out_valid", out_valid, 0);
      end else begin
        redir = interrupt | redirect_valid | pc_low_load | pc_high_load;
        pop   = out_valid && out_ready;
        if (out_valid) begin
          check("m_head_pc", out_pc, m_head);
          check("m_head_instr", out_instr, mem_f(m_head[19:0]));
          check("m_valid_has_fetch", m_out > 0, 1);
        end else begin
          check("m_idle_pc", out_pc, 0);
          check("m_idle_instr", out_instr, 0);
        end
        if (redir) check("m_req_on_redirect", imem_req, 0);
        else if (m_out + 1 <= DEPTH) check("m_req_credit", imem_req, 1);
        if (imem_req) begin
          check("m_req_addr", imem_addr, m_fetch[19:0]);
          check("m_credit_bound", (m_out - int'(pop) + 1) <= DEPTH, 1);
        end
        if (pop) begin
          m_head++;
          m_out--;
        end
        if (redir) begin
          if (interrupt) tgt = 32'h0;
          else if (redirect_valid) tgt = redirect_addr;
          else begin
            tgt = m_fetch;
            if (pc_low_load)  tgt[15:0]  = pop_data;
            if (pc_high_load) tgt[31:16] = pop_data;
          end
          m_fetch = tgt;
          m_head  = tgt;
          m_out   = 0;
        end else if (imem_req) begin
          m_fetch++;
          m_out++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of the first cycle after release.
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    interrupt = 1'b0;
    pc_low_load = 1'b0;
    pc_high_load = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] t1_instr [4];
  int          n;

  initial begin
    t1_instr[0] = 16'hAAA1;
    t1_instr[1] = 16'hBBB2;
    t1_instr[2] = 16'hCCC3;
    t1_instr[3] = 16'hDDD4;

    // Reset release and streaming with decode always ready.
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    check("t1_req0", imem_req, 1);
    check("t1_addr0", imem_addr, 32'h20);
    check("t1_valid0", out_valid, 0);
    tick();
    @(negedge clk);
    check("t1_valid1", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("t1_valid", out_valid, 1);
      check("t1_pc", out_pc, 32'h20 + i);
      check("t1_instr", out_instr, t1_instr[i]);
    end

    // Stall: credit limits fetch to DEPTH reads, release drains back-to-back.
    do_reset();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req) n++;
      tick();
    end
    check("t2_req_count", n, 4);
    @(negedge clk);
    check("t2_req_stalled", imem_req, 0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_drain_valid", out_valid, 1);
      check("t2_drain_pc", out_pc, 32'h20 + i);
      if (i == 0) begin
        check("t2_resume_req", imem_req, 1);
        check("t2_resume_addr", imem_addr, 32'h24);
      end
      tick();
    end

    // Redirect with three queued entries and a read in flight.
    do_reset();
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_addr = 32'h100;
    @(negedge clk);
    check("t3_pre_valid", out_valid, 1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t3_r1_req", imem_req, 1);
    check("t3_r1_addr", imem_addr, 32'h100);
    check("t3_r1_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("t3_r2_valid", out_valid, 0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_r3_valid", out_valid, 1);
    check("t3_r3_pc", out_pc, 32'h100);

    // Interrupt beats a simultaneous branch redirect.
    tick();
    interrupt = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 32'h200;
    tick();
    interrupt = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_int_addr", imem_addr, 32'h0);
    tick();
    tick();
    @(negedge clk);
    check("t4_int_valid", out_valid, 1);
    check("t4_int_pc", out_pc, 32'h0);

    // PC halves from the stack on consecutive cycles.
    tick();
    pc_low_load = 1'b1;
    pop_data = 16'h1234;
    tick();
    pc_low_load = 1'b0;
    pc_high_load = 1'b1;
    pop_data = 16'h0001;
    tick();
    pc_high_load = 1'b0;
    @(negedge clk);
    check("t4_pop_req", imem_req, 1);
    check("t4_pop_addr", imem_addr, 32'h11234);
    tick();
    tick();
    @(negedge clk);
    check("t4_pop_pc", out_pc, 32'h0001_1234);

    // Handshake in the redirect cycle.
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_addr = 32'h300;
    @(negedge clk);
    check("t5_hs_valid", out_valid, 1);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t5_empty_valid", out_valid, 0);
    check("t5_empty_instr", out_instr, 0);
    check("t5_empty_pc", out_pc, 0);
    tick();
    tick();
    @(negedge clk);
    check("t5_next_pc", out_pc, 32'h300);

    // Asynchronous reset with two entries queued.
    do_reset();
    repeat (3) tick();
    @(negedge clk);
    check("t6_pre_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_valid", out_valid, 0);
    check("t6_async_pc", out_pc, 0);
    check("t6_async_instr", out_instr, 0);
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_restart_addr", imem_addr, 32'h20);
    tick();
    tick();
    @(negedge clk);
    check("t6_restart_pc", out_pc, 32'h20);
    check("t6_restart_instr", out_instr, 16'hAAA1);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a prefetch queue. Drives a synchronous instruction memory, tracks the fetch PC, and buffers fetched {pc, instruction} pairs so decode can stall without stopping fetch. Redirects (branch/call, interrupt, stack-popped PC halves) flush the queue and kill in-flight reads. Sits between the instruction memory and the IF/ID boundary.

## Interface
Parameters:
- ADDR_W, 32, fetch PC width
- INSTR_W, 16, instruction width
- MEM_ADDR_W, 20, instruction memory address width; low bits of the PC
- DEPTH, 4, queue entries; power of two, at least 2
- RESET_PC, 32'h20, first fetch address after reset
- INT_VECTOR, 32'h0, fetch address on interrupt

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  read request this cycle
- imem_addr  out  MEM_ADDR_W  fetch_pc[MEM_ADDR_W-1:0]
- imem_data  in  INSTR_W  read data; valid the cycle after the request
- redirect_valid  in  1  branch/call redirect
- redirect_addr  in  ADDR_W  redirect target
- interrupt  in  1  redirect to INT_VECTOR
- pc_low_load  in  1  load fetch_pc[15:0] from pop_data
- pc_high_load  in  1  load fetch_pc[31:16] from pop_data
- pop_data  in  16  popped PC half
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction; 0 (NOP) when out_valid=0
- out_pc  out  ADDR_W  head PC; 0 when out_valid=0

## Operation
- State: fetch_pc, queue (count 0..DEPTH), inflight flag, kill flag.
- Issue: imem_req=1 when no redirect event this cycle and count + inflight + 1 <= DEPTH. On issue: fetch_pc += 1, inflight set for next cycle with captured pc.
- Return: when inflight and not kill, enqueue {captured pc, imem_data} at end of cycle.
- Dequeue: out_valid && out_ready pops head. Enqueue and dequeue in the same cycle leave count unchanged.
- Redirect event priority: interrupt > redirect_valid > pc_high_load/pc_low_load. Winner sets fetch_pc: INT_VECTOR; redirect_addr; or replaces the addressed half(s) with pop_data. If both load bits are set, both halves take pop_data.
- Redirect effects, same cycle: imem_req=0; queue cleared at end of cycle; kill set, so the response arriving next cycle is discarded. A handshake in the redirect cycle still counts as consumed.
- Overflow cannot occur because credit counts in-flight reads. An enqueue into a full queue is a design error; assert it in simulation.

## Timing
- Reset (async): fetch_pc=RESET_PC, count=0, inflight=0, kill=0, out_valid=0, out_instr=0, out_pc=0. imem_req=1 in the first cycle after rst deasserts.
- Fetch latency: request in cycle N, data captured at end of N+1, out_valid in N+2.
- Steady state with out_ready=1: one instruction per cycle, PCs consecutive.
- Redirect in cycle R: first request to the target in R+1; its instruction is visible in R+3. No stale instruction appears after R.
- Back-to-back redirects: each restarts the sequence; the last one wins.
- Stall (out_ready=0): fetch continues until count + inflight = DEPTH, then imem_req=0. On release, requests resume the same cycle.
- Address wrap: fetch_pc increments modulo 2^ADDR_W. imem_addr truncates.
- rst asserted mid-operation: everything returns to reset values immediately. In-flight data is ignored.

## Structure
- Package fetch_pkg holds:
  - NOP encoding (0)
  - default RESET_PC and INT_VECTOR
  - the typedef of the queue entry struct {pc, instr}
- Sub-module fetch_fifo: circular buffer with read/write pointers of $clog2(DEPTH) bits, count of $clog2(DEPTH)+1 bits, synchronous flush, and async reset.
- The top level holds fetch_pc, the redirect priority mux, issue credit, and the inflight/kill flags.

## Test plan
- Reset and release with out_ready=1, memory[0x20..0x23]=A,B,C,D: out_valid first high 2 cycles after release with out_pc=0x20, out_instr=A, then B, C, D one per cycle.
- out_ready=0 for 10 cycles with DEPTH=4: exactly 4 requests issued (0x20..0x23), then imem_req=0. On release, 4 back-to-back outputs and fetching resumes at 0x24.
- redirect_valid with redirect_addr=0x100 while the queue holds 3 entries and a read is in flight: those entries never appear on the output, and the next output is out_pc=0x100, 3 cycles later.
- interrupt and redirect_valid=0x200 in the same cycle: the next output pc is 0x0. pc_low_load=0x1234 then pc_high_load=0x0001 on consecutive cycles: fetch resumes at 0x00011234.
- Handshake in the redirect cycle: the head is consumed exactly once. The queue is empty afterwards with out_instr=0.
- rst asserted mid-stream with 2 entries queued: out_valid=0 immediately. After release, fetch restarts at 0x20.
